// File: rtl/t09_sound_event_sequencer.sv
// Snake-game sound sequencer: turns collision and direction events into timed tones
// with priority DIR > BAD > GOOD, a pending queue, and a square-wave buzzer output.
module t09_sound_event_sequencer #(
   parameter int FREQ_W = 8,
   parameter int DUR_W  = 16,
   parameter int DIR_W  = 4,
   parameter int GOOD_F = 107,
   parameter int BAD_F  = 151,
   parameter int DIR_F  = 179,
   parameter int GOOD_D = 6000,
   parameter int BAD_D  = 12000,
   parameter int DIR_D  = 3000,
   parameter int GAP_D  = 500,
   parameter int PRESC  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              goodColl_i,
   input  logic              badColl_i,
   input  logic [DIR_W-1:0]  direction_i,
   input  logic              mute_i,
   output logic [FREQ_W-1:0] freq,
   output logic              tone_o,
   output logic              playing_o,
   output logic [2:0]        pending_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   // Sounds are one-hot {dir,bad,good}; as unsigned values they order by priority.
   localparam logic [2:0] SND_NONE = 3'b000;
   localparam logic [2:0] SND_GOOD = 3'b001;
   localparam logic [2:0] SND_BAD  = 3'b010;
   localparam logic [2:0] SND_DIR  = 3'b100;

   localparam int HP_W = FREQ_W + $clog2(PRESC);

   localparam logic [FREQ_W-1:0] GOOD_CODE = FREQ_W'(GOOD_F);
   localparam logic [FREQ_W-1:0] BAD_CODE  = FREQ_W'(BAD_F);
   localparam logic [FREQ_W-1:0] DIR_CODE  = FREQ_W'(DIR_F);
   localparam logic [DUR_W-1:0]  GOOD_LEN  = DUR_W'(GOOD_D - 1);
   localparam logic [DUR_W-1:0]  BAD_LEN   = DUR_W'(BAD_D - 1);
   localparam logic [DUR_W-1:0]  DIR_LEN   = DUR_W'(DIR_D - 1);
   localparam logic [DUR_W-1:0]  GAP_LEN   = DUR_W'(GAP_D - 1);
   localparam logic [HP_W-1:0]   PRESC_HP  = HP_W'(PRESC);

   function automatic logic [2:0] pick_top(input logic [2:0] req);
      logic [2:0] sel;
      if (req[2]) begin
         sel = SND_DIR;
      end else if (req[1]) begin
         sel = SND_BAD;
      end else if (req[0]) begin
         sel = SND_GOOD;
      end else begin
         sel = SND_NONE;
      end
      return sel;
   endfunction

   function automatic logic [FREQ_W-1:0] code_of(input logic [2:0] snd);
      logic [FREQ_W-1:0] code;
      case (snd)
         SND_DIR:  code = DIR_CODE;
         SND_BAD:  code = BAD_CODE;
         SND_GOOD: code = GOOD_CODE;
         default:  code = {FREQ_W{1'b0}};
      endcase
      return code;
   endfunction

   function automatic logic [DUR_W-1:0] len_of(input logic [2:0] snd);
      logic [DUR_W-1:0] len;
      case (snd)
         SND_DIR:  len = DIR_LEN;
         SND_BAD:  len = BAD_LEN;
         SND_GOOD: len = GOOD_LEN;
         default:  len = {DUR_W{1'b0}};
      endcase
      return len;
   endfunction

   logic [1:0]        state_r;
   logic [2:0]        cur_r;
   logic [2:0]        pend_r;
   logic [DUR_W-1:0]  cnt_r;
   logic [HP_W-1:0]   hp_cnt_r;
   logic              ph_r;
   logic              good_q_r;
   logic              bad_q_r;
   logic [DIR_W-1:0]  dir_q_r;

   logic [1:0]        state_nx_s;
   logic [2:0]        cur_nx_s;
   logic [2:0]        pend_nx_s;
   logic [DUR_W-1:0]  cnt_nx_s;
   logic [HP_W-1:0]   hp_nx_s;
   logic              ph_nx_s;
   logic [2:0]        ev_s;
   logic [2:0]        top_s;
   logic              start_s;
   logic [HP_W-1:0]   hp_lim_s;
   logic              play_nx_s;
   logic [FREQ_W-1:0] code_nx_s;
   logic [FREQ_W-1:0] freq_nx_s;
   logic              tone_nx_s;

   assign ev_s = {(direction_i != dir_q_r) & (|direction_i),
                  badColl_i & ~bad_q_r,
                  goodColl_i & ~good_q_r};

   // Next-state, pending-queue and tone-phase logic
   always_comb begin
      state_nx_s = state_r;
      cur_nx_s   = cur_r;
      pend_nx_s  = pend_r;
      cnt_nx_s   = cnt_r;
      hp_nx_s    = hp_cnt_r;
      ph_nx_s    = ph_r;
      top_s      = SND_NONE;
      start_s    = 1'b0;
      hp_lim_s   = HP_W'(code_of(cur_r)) * PRESC_HP - HP_W'(1'b1);
      case (state_r)
         ST_IDLE: begin
            top_s = pick_top(ev_s | pend_r);
            if (top_s != SND_NONE) begin
               state_nx_s = ST_PLAY;
               cur_nx_s   = top_s;
               pend_nx_s  = (ev_s | pend_r) & ~top_s;
               start_s    = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_PLAY: begin
            top_s = pick_top(ev_s);
            // Same sound retriggers, higher sound preempts; the preempted one is dropped.
            if ((top_s != SND_NONE) && (top_s >= cur_r)) begin
               cur_nx_s  = top_s;
               pend_nx_s = (pend_r | ev_s) & ~top_s;
               start_s   = 1'b1;
            end else begin
               pend_nx_s = pend_r | ev_s;
               if (cnt_r == {DUR_W{1'b0}}) begin
                  state_nx_s = ST_GAP;
                  cnt_nx_s   = GAP_LEN;
                  hp_nx_s    = {HP_W{1'b0}};
                  ph_nx_s    = 1'b0;
               end else begin
                  cnt_nx_s = cnt_r - DUR_W'(1'b1);
                  if (hp_cnt_r == hp_lim_s) begin
                     hp_nx_s = {HP_W{1'b0}};
                     ph_nx_s = ~ph_r;
                  end else begin
                     hp_nx_s = hp_cnt_r + HP_W'(1'b1);
                  end
               end
            end
         end
         ST_GAP: begin
            pend_nx_s = pend_r | ev_s;
            hp_nx_s   = {HP_W{1'b0}};
            ph_nx_s   = 1'b0;
            if (cnt_r == {DUR_W{1'b0}}) begin
               state_nx_s = ST_IDLE;
            end else begin
               cnt_nx_s = cnt_r - DUR_W'(1'b1);
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            cur_nx_s   = SND_NONE;
            pend_nx_s  = 3'b000;
         end
      endcase
      if (start_s) begin
         cnt_nx_s = len_of(cur_nx_s);
         hp_nx_s  = {HP_W{1'b0}};
         ph_nx_s  = 1'b0;
      end else begin
         cnt_nx_s = cnt_nx_s;
      end
      play_nx_s = (state_nx_s == ST_PLAY);
      code_nx_s = code_of(cur_nx_s);
      if (play_nx_s && !mute_i) begin
         freq_nx_s = code_nx_s;
         tone_nx_s = ph_nx_s & (code_nx_s != {FREQ_W{1'b0}});
      end else begin
         freq_nx_s = {FREQ_W{1'b0}};
         tone_nx_s = 1'b0;
      end
   end

   // State, counters, edge detectors and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cur_r     <= SND_NONE;
         pend_r    <= 3'b000;
         cnt_r     <= {DUR_W{1'b0}};
         hp_cnt_r  <= {HP_W{1'b0}};
         ph_r      <= 1'b0;
         freq      <= {FREQ_W{1'b0}};
         tone_o    <= 1'b0;
         playing_o <= 1'b0;
         pending_o <= 3'b000;
      end else begin
         state_r   <= state_nx_s;
         cur_r     <= cur_nx_s;
         pend_r    <= pend_nx_s;
         cnt_r     <= cnt_nx_s;
         hp_cnt_r  <= hp_nx_s;
         ph_r      <= ph_nx_s;
         freq      <= freq_nx_s;
         tone_o    <= tone_nx_s;
         playing_o <= play_nx_s;
         pending_o <= pend_nx_s;
      end
      // Loaded in reset too, so inputs held across reset release raise no event.
      good_q_r <= goodColl_i;
      bad_q_r  <= badColl_i;
      dir_q_r  <= direction_i;
   end

endmodule

// File: tb/tb_t09_sound_event_sequencer.sv
// Scoreboard bench for the sound event sequencer: expected per-cycle outputs are queued
// as stimulus is applied and compared one entry per clock.
module tb_t09_sound_event_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       good;
   logic       bad;
   logic [3:0] dir;
   logic       mute;
   logic [7:0] freq, freq2;
   logic       tone, tone2, playing, playing2;
   logic [2:0] pend, pend2;

   typedef struct packed {
      logic [7:0] f;
      logic       pl;
      logic       t2c;
      logic [7:0] f2;
      logic       t2;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   t09_sound_event_sequencer #(
      .GOOD_D(8), .BAD_D(12), .DIR_D(4), .GAP_D(2), .PRESC(1)
   ) u_dut (
      .clk(clk), .rst(rst), .goodColl_i(good), .badColl_i(bad), .direction_i(dir),
      .mute_i(mute), .freq(freq), .tone_o(tone), .playing_o(playing), .pending_o(pend)
   );

   // Second instance with a tiny freq code so the square wave toggles within one tone
   t09_sound_event_sequencer #(
      .GOOD_F(3), .GOOD_D(20), .BAD_D(12), .DIR_D(4), .GAP_D(2), .PRESC(2)
   ) u_tone (
      .clk(clk), .rst(rst), .goodColl_i(good), .badColl_i(bad), .direction_i(dir),
      .mute_i(mute), .freq(freq2), .tone_o(tone2), .playing_o(playing2), .pending_o(pend2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic [7:0] f, input logic pl, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.f   = f;
         e.pl  = pl;
         e.t2c = 1'b0;
         e.f2  = 8'd0;
         e.t2  = 1'b0;
         sb_q.push_back(e);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk("sb_depth", 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk("freq", 32'(freq), 32'(e.f));
         chk("playing", 32'(playing), 32'(e.pl));
         chk("tone", 32'(tone), 32'd0);
         if (e.t2c) begin
            chk("freq2", 32'(freq2), 32'(e.f2));
            chk("tone2", 32'(tone2), 32'(e.t2));
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      exp_t e;
      rst = 1'b1; good = 1'b0; bad = 1'b0; dir = 4'b0000; mute = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_freq", 32'(freq), 32'd0);
      chk("rst_tone", 32'(tone), 32'd0);
      chk("rst_playing", 32'(playing), 32'd0);
      chk("rst_pending", 32'(pend), 32'd0);
      rst = 1'b0;
      push(8'd0, 1'b0, 2); run(2);

      // single good tone, input held high
      good = 1'b1;
      push(8'd107, 1'b1, 8); push(8'd0, 1'b0, 6); run(14);
      chk("s1_pend", 32'(pend), 32'd0);
      good = 1'b0; push(8'd0, 1'b0, 2); run(2);

      // bad preempts good on its third cycle
      good = 1'b1; push(8'd107, 1'b1, 3); run(3);
      bad = 1'b1; push(8'd151, 1'b1, 12); push(8'd0, 1'b0, 4); run(16);
      chk("s2_pend", 32'(pend), 32'd0);
      good = 1'b0; bad = 1'b0; push(8'd0, 1'b0, 2); run(2);

      // good during bad is pended and played after the gap
      bad = 1'b1; push(8'd151, 1'b1, 2); run(2);
      good = 1'b1; push(8'd151, 1'b1, 1); run(1);
      chk("s3_pend", 32'(pend), 32'd1);
      push(8'd151, 1'b1, 9); push(8'd0, 1'b0, 3); push(8'd107, 1'b1, 1); run(13);
      chk("s3_pend_clr", 32'(pend), 32'd0);
      push(8'd107, 1'b1, 7); push(8'd0, 1'b0, 4); run(11);
      good = 1'b0; bad = 1'b0; push(8'd0, 1'b0, 2); run(2);

      // three simultaneous events play in priority order
      good = 1'b1; bad = 1'b1; dir = 4'b0010;
      push(8'd179, 1'b1, 1); run(1);
      chk("s4_pend", 32'(pend), 32'd3);
      push(8'd179, 1'b1, 3); push(8'd0, 1'b0, 3); push(8'd151, 1'b1, 1); run(7);
      chk("s4_pend_b", 32'(pend), 32'd1);
      push(8'd151, 1'b1, 11); push(8'd0, 1'b0, 3); push(8'd107, 1'b1, 8); push(8'd0, 1'b0, 4);
      run(26);
      chk("s4_pend_end", 32'(pend), 32'd0);
      good = 1'b0; bad = 1'b0; push(8'd0, 1'b0, 2); run(2);

      // new nonzero direction retones, return to zero does not
      dir = 4'b0100; push(8'd179, 1'b1, 4); push(8'd0, 1'b0, 3); run(7);
      dir = 4'b0000; push(8'd0, 1'b0, 4); run(4);

      // mute during bad tone, then reset mid-tone drops pending
      bad = 1'b1; push(8'd151, 1'b1, 2); run(2);
      mute = 1'b1; good = 1'b1; push(8'd0, 1'b1, 1); run(1);
      chk("mute_pend", 32'(pend), 32'd1);
      push(8'd0, 1'b1, 1); run(1);
      rst = 1'b1; push(8'd0, 1'b0, 1); run(1);
      chk("rst_mid_pend", 32'(pend), 32'd0);
      rst = 1'b0; push(8'd0, 1'b0, 4); run(4);
      mute = 1'b0; push(8'd0, 1'b0, 2); run(2);

      // square wave: code 3, prescale 2 -> half-period of 6 cycles
      good = 1'b0; bad = 1'b0; push(8'd0, 1'b0, 2); run(2);
      good = 1'b1;
      for (int n = 0; n < 22; n++) begin
         e.f   = (n < 8) ? 8'd107 : 8'd0;
         e.pl  = (n < 8) ? 1'b1 : 1'b0;
         e.t2c = 1'b1;
         e.f2  = (n < 20) ? 8'd3 : 8'd0;
         e.t2  = (n < 20) ? 1'((n / 6) % 2) : 1'b0;
         sb_q.push_back(e);
      end
      run(22);
      chk("u2_pend", 32'(pend2), 32'd0);
      chk("u2_playing", 32'(playing2), 32'd0);
      chk("sb_left", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
